// File: rtl/apb_master.sv
`default_nettype none
// ============================================================================
// Module   : apb_master
// Purpose  : Single-outstanding APB requester. One command is accepted on a
//            valid/ready handshake, issued as a SETUP + ACCESS transfer, and
//            returned as a held response. A wait-state limit aborts transfers
//            whose completer never asserts PREADY.
// Ports    : PCLK, PRESET             clock, async active-high reset
//            cmd_valid/cmd_ready      command handshake
//            cmd_write/addr/wdata     command payload
//            rsp_valid/rsp_ready      response handshake
//            rsp_rdata/rsp_err        response payload (err = timeout abort)
//            PSEL/PENABLE/PWRITE/
//            PADDR/PWDATA             APB request (all registered)
//            PRDATA/PREADY            APB completer response
// Revision : 1.0 - initial release
// ============================================================================
module apb_master #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic [DATA_WIDTH-1:0] PWDATA,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PREADY
);

    localparam int            CW          = $clog2(TIMEOUT + 1);
    // Counter value on the last permitted ACCESS cycle.
    localparam logic [CW-1:0] c_LAST_WAIT = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t                state_q;
    logic [CW-1:0]         wait_cnt_q;
    logic                  psel_q;
    logic                  penable_q;
    logic                  pwrite_q;
    logic [ADDR_WIDTH-1:0] paddr_q;
    logic [DATA_WIDTH-1:0] pwdata_q;
    logic                  rsp_valid_q;
    logic [DATA_WIDTH-1:0] rsp_rdata_q;
    logic                  rsp_err_q;

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q     <= S_IDLE;
            wait_cnt_q  <= '0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (cmd_valid) begin
                        state_q   <= S_SETUP;
                        paddr_q   <= cmd_addr;
                        pwrite_q  <= cmd_write;
                        // Reads drive a zero data bus rather than stale data.
                        pwdata_q  <= cmd_write ? cmd_wdata : '0;
                        psel_q    <= 1'b1;
                        penable_q <= 1'b0;
                    end
                end
                S_SETUP: begin
                    state_q    <= S_ACCESS;
                    penable_q  <= 1'b1;
                    wait_cnt_q <= '0;
                end
                S_ACCESS: begin
                    // PREADY wins over the abort on the final allowed cycle.
                    if (PREADY) begin
                        state_q     <= S_RESP;
                        psel_q      <= 1'b0;
                        penable_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= pwrite_q ? '0 : PRDATA;
                        rsp_err_q   <= 1'b0;
                    end else if (wait_cnt_q == c_LAST_WAIT) begin
                        state_q     <= S_RESP;
                        psel_q      <= 1'b0;
                        penable_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= '0;
                        rsp_err_q   <= 1'b1;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + CW'(1);
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        state_q     <= S_IDLE;
                        rsp_valid_q <= 1'b0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign cmd_ready = (state_q == S_IDLE);
    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;
    assign PWRITE    = pwrite_q;
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule
`default_nettype wire

// File: tb/tb_apb_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb_master
// Purpose  : Scoreboard bench for apb_master with a small APB completer model
//            (16-word memory, programmable wait states, PREADY tie-low).
// Revision : 1.0 - initial release
// ============================================================================
module tb_apb_master;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int TO = 16;

    logic          PCLK = 1'b0;
    logic          PRESET;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          PSEL;
    logic          PENABLE;
    logic          PWRITE;
    logic [AW-1:0] PADDR;
    logic [DW-1:0] PWDATA;
    logic [DW-1:0] PRDATA;
    logic          PREADY;

    apb_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
        .PCLK      (PCLK),
        .PRESET    (PRESET),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY)
    );

    always #5 PCLK = ~PCLK;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge PCLK) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [DW-1:0] rdata;
        logic          err;
        int            acc;
    } exp_t;
    exp_t sbq[$];

    task automatic exp_push(input logic [DW-1:0] rd, input logic er, input int acc);
        exp_t e;
        e.rdata = rd;
        e.err   = er;
        e.acc   = acc;
        sbq.push_back(e);
    endtask

    // ---------------- completer model ----------------
    int            waits   = 0;
    bit            tie_low = 1'b0;
    logic [31:0]   mem [0:15];
    bit            pend    = 1'b0;
    int            pidx    = 0;
    logic [31:0]   pdat    = '0;
    int            wcnt    = 0;

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = '0;
        PREADY = 1'b0;
        PRDATA = 32'hBAD0_BAD0;
        forever begin
            @(posedge PCLK);
            #1;
            if (pend) begin
                mem[pidx] = pdat;
                pend      = 1'b0;
            end
            PREADY = 1'b0;
            PRDATA = 32'hBAD0_BAD0;
            if (PSEL && !PENABLE) begin
                wcnt = 0;
            end else if (PSEL && PENABLE) begin
                if (!tie_low && wcnt >= waits) begin
                    PREADY = 1'b1;
                    if (PWRITE) begin
                        pend = 1'b1;
                        pidx = int'(PADDR[5:2]);
                        pdat = PWDATA;
                    end else begin
                        PRDATA = mem[PADDR[5:2]];
                    end
                end else begin
                    wcnt++;
                end
            end
        end
    end

    // ---------------- monitor ----------------
    int            acc_cnt  = 0;
    logic [AW-1:0] setup_addr = '0;
    logic          setup_wr   = 1'b0;
    logic          prev_psel  = 1'b0;
    bit            rec        = 1'b0;
    int            rises[$];

    initial begin
        exp_t e;
        forever begin
            @(negedge PCLK);
            if (PRESET) begin
                acc_cnt = 0;
            end else begin
                if (PSEL && !PENABLE) begin
                    acc_cnt    = 0;
                    setup_addr = PADDR;
                    setup_wr   = PWRITE;
                end
                if (PSEL && PENABLE) begin
                    acc_cnt++;
                    chk("paddr_stable", PADDR, setup_addr);
                    chk("pwrite_stable", PWRITE, setup_wr);
                end
                if (rsp_valid && rsp_ready) begin
                    chk("rsp_expected", sbq.size() != 0, 1);
                    if (sbq.size() != 0) begin
                        e = sbq.pop_front();
                        chk("rsp_rdata", rsp_rdata, e.rdata);
                        chk("rsp_err", rsp_err, e.err);
                        chk("access_cycles", acc_cnt, e.acc);
                    end
                end
                if (rec && PSEL && !prev_psel) rises.push_back(cyc);
            end
            prev_psel = PSEL;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        int g = 0;
        @(posedge PCLK);
        #1;
        while (!cmd_ready && g < 200) begin
            @(posedge PCLK);
            #1;
            g++;
        end
        chk("send_cmd_ready", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        @(posedge PCLK);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string nm);
        bit seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge PCLK);
            if (rsp_valid) begin
                seen = 1'b1;
                break;
            end
        end
        chk(nm, seen, 1);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 300; i++) begin
            @(negedge PCLK);
            if (sbq.size() == 0 && cmd_ready) break;
        end
        chk("drain", sbq.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    // ---------------- main sequence ----------------
    initial begin
        int n;
        PRESET    = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        rsp_ready = 1'b1;

        // Reset state
        repeat (3) @(negedge PCLK);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_psel", PSEL, 0);
        chk("rst_penable", PENABLE, 0);
        chk("rst_pwrite", PWRITE, 0);
        chk("rst_paddr", PADDR, 0);
        chk("rst_pwdata", PWDATA, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_rsp_err", rsp_err, 0);
        @(posedge PCLK);
        #1;
        PRESET = 1'b0;

        // Write DEADBEEF to 0x8 with two wait states -> 3 ACCESS cycles
        waits = 2;
        exp_push(32'h0, 1'b0, 3);
        send(1'b1, 32'h0000_0008, 32'hDEAD_BEEF);
        wait_done();
        chk("mem_word2", mem[2], 32'hDEAD_BEEF);

        // Read 0x8, zero wait: SETUP at N+1, ACCESS at N+2, response at N+3
        waits = 0;
        exp_push(32'hDEAD_BEEF, 1'b0, 1);
        send(1'b0, 32'h0000_0008, 32'hFFFF_FFFF);
        @(negedge PCLK);
        chk("lat_setup_psel", PSEL, 1);
        chk("lat_setup_penable", PENABLE, 0);
        chk("lat_setup_paddr", PADDR, 32'h8);
        chk("lat_setup_pwdata", PWDATA, 0);
        @(negedge PCLK);
        chk("lat_access_psel", PSEL, 1);
        chk("lat_access_penable", PENABLE, 1);
        chk("lat_access_pwdata", PWDATA, 0);
        @(negedge PCLK);
        chk("lat_rsp_valid", rsp_valid, 1);
        chk("lat_rsp_rdata", rsp_rdata, 32'hDEAD_BEEF);
        chk("lat_rsp_psel", PSEL, 0);
        wait_done();

        // Second pattern: write 0x10 with one wait state, then read it back
        waits = 1;
        exp_push(32'h0, 1'b0, 2);
        send(1'b1, 32'h0000_0010, 32'hA5A5_5A5A);
        wait_done();
        chk("mem_word4", mem[4], 32'hA5A5_5A5A);
        waits = 0;
        exp_push(32'hA5A5_5A5A, 1'b0, 1);
        send(1'b0, 32'h0000_0010, 32'h0);
        wait_done();

        // Timeout: PREADY tied low -> 16 ACCESS cycles then an error response
        tie_low = 1'b1;
        exp_push(32'h0, 1'b1, TO);
        send(1'b0, 32'h0000_0008, 32'h0);
        wait_rsp("timeout_rsp_seen");
        chk("timeout_psel_after", PSEL, 0);
        chk("timeout_err", rsp_err, 1);
        wait_done();
        tie_low = 1'b0;

        // Response back-pressure: RESP held with stable payload
        rsp_ready = 1'b0;
        exp_push(32'hDEAD_BEEF, 1'b0, 1);
        send(1'b0, 32'h0000_0008, 32'h0);
        wait_rsp("hold_rsp_seen");
        for (int i = 0; i < 5; i++) begin
            @(negedge PCLK);
            chk("hold_rsp_valid", rsp_valid, 1);
            chk("hold_rsp_rdata", rsp_rdata, 32'hDEAD_BEEF);
            chk("hold_rsp_err", rsp_err, 0);
            chk("hold_cmd_ready", cmd_ready, 0);
            chk("hold_psel", PSEL, 0);
        end
        @(posedge PCLK);
        #1;
        rsp_ready = 1'b1;
        wait_done();

        // Reset pulsed in the middle of ACCESS: transfer discarded
        waits = 3;
        send(1'b0, 32'h0000_0008, 32'h0);
        n = 0;
        while (!(PSEL && PENABLE) && n < 20) begin
            @(negedge PCLK);
            n++;
        end
        chk("midrst_in_access", PSEL && PENABLE, 1);
        PRESET = 1'b1;
        #1;
        chk("midrst_psel", PSEL, 0);
        chk("midrst_penable", PENABLE, 0);
        chk("midrst_cmd_ready", cmd_ready, 1);
        @(posedge PCLK);
        #1;
        PRESET = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge PCLK);
            chk("midrst_no_rsp", rsp_valid, 0);
        end
        waits = 0;
        exp_push(32'hDEAD_BEEF, 1'b0, 1);
        send(1'b0, 32'h0000_0008, 32'h0);
        wait_done();

        // Back-to-back with cmd_valid held: one transfer every 4 cycles
        rises.delete();
        rec = 1'b1;
        for (int i = 0; i < 4; i++) exp_push(32'hDEAD_BEEF, 1'b0, 1);
        @(posedge PCLK);
        #1;
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 32'h0000_0008;
        n = 0;
        for (int g = 0; g < 100 && n < 4; g++) begin
            @(negedge PCLK);
            if (cmd_ready) n++;
        end
        @(posedge PCLK);
        #1;
        cmd_valid = 1'b0;
        wait_done();
        rec = 1'b0;
        chk("b2b_rises", rises.size(), 4);
        for (int i = 1; i < rises.size(); i++)
            chk("b2b_spacing", rises[i] - rises[i-1], 4);

        repeat (2) @(negedge PCLK);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/apb_master.md
APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set PWDATA/PRDATA/cmd_wdata/rsp_rdata width.
REQ-002 Parameter ADDR_WIDTH, default 32, SHALL set PADDR/cmd_addr width (byte address).
REQ-003 Parameter TIMEOUT, default 16, SHALL set the maximum ACCESS cycles before abort; legal values are 1 and above.
REQ-004 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-005 PCLK  in  1  clock; all state changes on its rising edge.
REQ-006 PRESET  in  1  asynchronous active-high reset.
REQ-007 cmd_valid  in  1  command request.
REQ-008 cmd_ready  out  1  command accepted when high with cmd_valid at a rising edge.
REQ-009 cmd_write  in  1  1=write, 0=read.
REQ-010 cmd_addr  in  ADDR_WIDTH  byte address.
REQ-011 cmd_wdata  in  DATA_WIDTH  write data.
REQ-012 rsp_valid  out  1  response available.
REQ-013 rsp_ready  in  1  response consumed when high with rsp_valid at a rising edge.
REQ-014 rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and aborts.
REQ-015 rsp_err  out  1  1 = transfer aborted by timeout.
REQ-016 PSEL, PENABLE, PWRITE  out  1 each  APB controls.
REQ-017 PADDR  out  ADDR_WIDTH; PWDATA  out  DATA_WIDTH  APB address and data.
REQ-018 PRDATA  in  DATA_WIDTH; PREADY  in  1  APB completer response.

Function
REQ-019 The FSM SHALL have the states IDLE, SETUP, ACCESS and RESP, all registered.
REQ-020 cmd_ready SHALL be 1 exactly when the state is IDLE.
REQ-021 On accept, cmd_addr, cmd_write and cmd_wdata SHALL be registered, and the FSM SHALL move from IDLE to SETUP.
REQ-022 SETUP SHALL last exactly one cycle with PSEL=1 and PENABLE=0, then move to ACCESS.
REQ-023 ACCESS SHALL drive PSEL=1 and PENABLE=1, and SHALL stay in ACCESS until PREADY=1 is sampled or the timeout occurs.
REQ-024 PADDR and PWRITE SHALL come from the registered command and SHALL stay stable from SETUP through the last ACCESS cycle.
REQ-025 PWDATA SHALL carry the registered wdata for writes and 0 for reads.
REQ-026 In IDLE and RESP, PSEL=PENABLE=0; PADDR, PWRITE and PWDATA hold their last values.
REQ-027 When PREADY=1 is sampled in ACCESS:
- rsp_rdata SHALL take PRDATA for reads and 0 for writes;
- rsp_err SHALL be 0;
- the FSM SHALL move to RESP.
REQ-028 Wait counter, $clog2(TIMEOUT+1) bits:
- cleared on entry to ACCESS;
- increments on each ACCESS cycle where PREADY=0.
REQ-029 Abort: if PREADY=0 when the counter equals TIMEOUT-1, the FSM SHALL move to RESP with rsp_err=1 and rsp_rdata=0. ACCESS therefore lasts exactly TIMEOUT cycles.
REQ-030 If PREADY=1 arrives on the final allowed cycle, the transfer SHALL complete normally (rsp_err=0).
REQ-031 RESP SHALL drive rsp_valid=1, with rsp_rdata and rsp_err held stable until rsp_ready=1, then move to IDLE.
REQ-032 Latency with zero wait states SHALL be as follows, where N is the accept edge:
- SETUP in cycle N+1;
- ACCESS in cycle N+2;
- rsp_valid in cycle N+3.
REQ-033 Back-to-back throughput with zero wait states and rsp_ready=1 SHALL be one transfer per 4 cycles.
REQ-034 cmd_valid SHALL be ignored in every state other than IDLE; commands are never queued.

Reset
REQ-035 While PRESET=1, asynchronously, the block SHALL go to:
- state IDLE;
- PSEL, PENABLE, PWRITE, PADDR, PWDATA all 0;
- rsp_valid, rsp_rdata, rsp_err all 0;
- wait counter 0;
- cmd_ready=1.
REQ-036 Reset during SETUP, ACCESS or RESP SHALL drop PSEL and PENABLE immediately. The in-flight command SHALL be discarded with no response generated.

Verification
REQ-037 Write 0xDEADBEEF to 0x00000008, completer adds 2 wait states -> 1 SETUP cycle, 3 ACCESS cycles; rsp_valid=1, rsp_err=0, rsp_rdata=0; completer word 2 = 0xDEADBEEF.
REQ-038 Read 0x00000008, zero wait -> rsp_valid at accept+3 with rsp_rdata=0xDEADBEEF; PWDATA=0 during the transfer.
REQ-039 PREADY tied 0, TIMEOUT=16 -> exactly 16 ACCESS cycles, then rsp_err=1 and rsp_rdata=0; PSEL=0 on the following cycle.
REQ-040 rsp_ready held 0 for 5 cycles in RESP -> rsp_valid, rsp_rdata and rsp_err stable; cmd_ready=0; PSEL=0 throughout.
REQ-041 PRESET pulsed mid-ACCESS -> PSEL and PENABLE drop before the next edge and no rsp_valid appears; a following read of 0x00000008 completes normally.
REQ-042 cmd_valid held 1, rsp_ready=1, zero wait -> PSEL rising edges every 4 cycles, each transfer returning rsp_err=0.
